// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 (HD44780) bus blocks.
// Holds the read-FSM state encoding, the default bus timing shared with the
// write driver, and the position of the busy flag in the status byte.
package lcd1602_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TURN,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_RECOV,
        ST_REL
    } lcd_rd_state_t;

    // Default bus timing in clock cycles at 10 MHz.
    localparam int LCD_TURN_CYC = 1;
    localparam int LCD_T_AS_CYC = 1;
    localparam int LCD_T_EH_CYC = 5;
    localparam int LCD_T_H_CYC  = 1;
    localparam int LCD_T_EL_CYC = 5;
    localparam int LCD_POLL_MAX = 255;

    // Busy flag bit in the status byte returned by an RS=0 read.
    localparam int BF_BIT = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Down-counter that times one FSM phase.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   load      load load_val this cycle (N-1 for an N-cycle phase)
//   load_val  value loaded on load
//   zero      counter is 0: the current phase ends at the next edge
module lcd_phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only,
        // so every flop samples the values from before the edge.
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lcd1602_reader.sv
// Read-side companion to the LCD1602 write driver.
// Runs RW=1 bus cycles on the shared LCD pins and returns either the busy
// flag + address counter (RS=0) or a data byte (RS=1). Poll mode repeats
// status reads while BF=1, up to POLL_MAX reads, keeping the bus throughout.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_rs, req_poll             read type; poll forces RS=0
//   rsp_valid/rsp_data           one-cycle response pulse, byte held until next
//   rsp_timeout                  poll ended with BF still set
//   bus_req/bus_gnt              pin ownership handshake with the arbiter
//   lcd_en/lcd_rw/lcd_rs         LCD control pins
//   lcd_data_in                  DB7..DB0 from the pads
//   lcd_oeb                      1 = DB pads released for reading
module lcd1602_reader
    import lcd1602_pkg::*;
#(
    parameter int TURN_CYC = LCD_TURN_CYC,
    parameter int T_AS_CYC = LCD_T_AS_CYC,
    parameter int T_EH_CYC = LCD_T_EH_CYC,
    parameter int T_H_CYC  = LCD_T_H_CYC,
    parameter int T_EL_CYC = LCD_T_EL_CYC,
    parameter int POLL_MAX = LCD_POLL_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_rs,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_oeb
);

    localparam int TMR_MAX = max_int(max_int(max_int(TURN_CYC, T_AS_CYC),
                                             max_int(T_EH_CYC, T_H_CYC)), T_EL_CYC);
    localparam int TW  = $clog2(TMR_MAX + 1);
    localparam int PCW = $clog2(POLL_MAX + 1);

    localparam logic [TW-1:0]  LD_TURN = TW'(TURN_CYC - 1);
    localparam logic [TW-1:0]  LD_AS   = TW'(T_AS_CYC - 1);
    localparam logic [TW-1:0]  LD_EH   = TW'(T_EH_CYC - 1);
    localparam logic [TW-1:0]  LD_H    = TW'(T_H_CYC - 1);
    localparam logic [TW-1:0]  LD_EL   = TW'(T_EL_CYC - 1);
    localparam logic [PCW-1:0] POLL_MAX_C = PCW'(POLL_MAX);

    lcd_rd_state_t  state_q, state_d;
    logic           rs_q, rs_d;
    logic           poll_q, poll_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]     rd_data_q, rd_data_d;

    logic           req_ready_d, rsp_valid_d, rsp_timeout_d, bus_req_d;
    logic           lcd_en_d, lcd_rw_d, lcd_rs_d, lcd_oeb_d;
    logic [7:0]     rsp_data_d;

    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_zero;

    lcd_phase_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d       = state_q;
        rs_d          = rs_q;
        poll_d        = poll_q;
        poll_cnt_d    = poll_cnt_q;
        rd_data_d     = rd_data_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data;
        rsp_timeout_d = rsp_timeout;
        bus_req_d     = bus_req;
        lcd_en_d      = lcd_en;
        lcd_rw_d      = lcd_rw;
        lcd_rs_d      = lcd_rs;
        lcd_oeb_d     = lcd_oeb;
        tmr_load      = 1'b0;
        tmr_val       = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    rs_d       = req_poll ? 1'b0 : req_rs;
                    poll_d     = req_poll;
                    poll_cnt_d = '0;
                    bus_req_d  = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Pads are turned around on the grant edge, before E moves.
                if (bus_gnt) begin
                    lcd_rw_d  = 1'b1;
                    lcd_oeb_d = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_TURN;
                    state_d   = ST_TURN;
                end
            end
            ST_TURN: begin
                if (tmr_zero) begin
                    lcd_rs_d = rs_q;
                    tmr_load = 1'b1;
                    tmr_val  = LD_AS;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    lcd_en_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EH;
                    state_d  = ST_EHIGH;
                end
            end
            ST_EHIGH: begin
                // Sample on the edge that ends the last E-high cycle.
                if (tmr_zero) begin
                    lcd_en_d   = 1'b0;
                    rd_data_d  = lcd_data_in;
                    poll_cnt_d = (poll_cnt_q == POLL_MAX_C) ? poll_cnt_q
                                                            : poll_cnt_q + PCW'(1);
                    tmr_load   = 1'b1;
                    tmr_val    = LD_H;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_EL;
                    state_d  = ST_RECOV;
                end
            end
            ST_RECOV: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (poll_q && rd_data_q[BF_BIT] && (poll_cnt_q < POLL_MAX_C)) begin
                        tmr_val = LD_AS;
                        state_d = ST_SETUP;
                    end else begin
                        lcd_rw_d = 1'b0;
                        tmr_val  = LD_TURN;
                        state_d  = ST_REL;
                    end
                end
            end
            ST_REL: begin
                // Pads are reclaimed only after RW has been low for TURN_CYC.
                if (tmr_zero) begin
                    lcd_oeb_d     = 1'b0;
                    lcd_rs_d      = 1'b0;
                    bus_req_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = rd_data_q;
                    rsp_timeout_d = poll_q && rd_data_q[BF_BIT];
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rs_q        <= 1'b0;
            poll_q      <= 1'b0;
            poll_cnt_q  <= '0;
            rd_data_q   <= 8'h00;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_timeout <= 1'b0;
            bus_req     <= 1'b0;
            lcd_en      <= 1'b0;
            lcd_rw      <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_oeb     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            poll_q      <= poll_d;
            poll_cnt_q  <= poll_cnt_d;
            rd_data_q   <= rd_data_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_timeout <= rsp_timeout_d;
            bus_req     <= bus_req_d;
            lcd_en      <= lcd_en_d;
            lcd_rw      <= lcd_rw_d;
            lcd_rs      <= lcd_rs_d;
            lcd_oeb     <= lcd_oeb_d;
        end
    end

endmodule

// File: tb/tb_lcd1602_reader.sv
// Directed bench for lcd1602_reader. POLL_MAX is set to 4 so the poll limit
// is reachable; the LCD model drives model_mem[n] during the n-th E pulse of
// the current operation. A monitor checks bus-protocol rules every cycle.
module tb_lcd1602_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rs = 1'b0;
    logic       req_poll = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       bus_req;
    logic       bus_gnt = 1'b1;
    logic       lcd_en;
    logic       lcd_rw;
    logic       lcd_rs;
    logic [7:0] lcd_data_in;
    logic       lcd_oeb;

    int n_assert = 0;
    int n_fail   = 0;

    // LCD model state
    logic [7:0] model_mem [8];
    int         e_cnt = 0;
    int         e_base = 0;
    int         midx;

    // Monitor state
    logic prev_en = 1'b0;
    logic prev_rw = 1'b0;
    logic last_rs = 1'b0;
    logic seen_pulse = 1'b0;
    int   high_len = 0;
    int   low_len = 0;
    int   last_high_len = 0;

    always #5 clk = ~clk;

    lcd1602_reader #(.POLL_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs      (req_rs),
        .req_poll    (req_poll),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .lcd_en      (lcd_en),
        .lcd_rw      (lcd_rw),
        .lcd_rs      (lcd_rs),
        .lcd_data_in (lcd_data_in),
        .lcd_oeb     (lcd_oeb)
    );

    assign midx        = e_cnt - e_base;
    assign lcd_data_in = lcd_en ? model_mem[midx[2:0]] : 8'hEE;

    // Protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (lcd_en && prev_en) begin
            n_assert++;
            if (lcd_rw !== prev_rw) begin
                n_fail++;
                $display("FAIL rw_stable_while_en: lcd_rw=%b, required %b", lcd_rw, prev_rw);
            end
        end
        if (lcd_rw) begin
            n_assert++;
            if (lcd_oeb !== 1'b1) begin
                n_fail++;
                $display("FAIL oeb_while_rw: lcd_oeb=%b, required 1", lcd_oeb);
            end
        end
        if (lcd_en && !prev_en) begin
            last_rs = lcd_rs;
            if (seen_pulse) begin
                n_assert++;
                if (low_len < 5) begin
                    n_fail++;
                    $display("FAIL e_low_gap: %0d cycles, required >= 5", low_len);
                end
            end
            high_len = 1;
        end else if (lcd_en) begin
            high_len++;
        end
        if (!lcd_en && prev_en) begin
            last_high_len = high_len;
            e_cnt++;
            seen_pulse = 1'b1;
            low_len = 1;
        end else if (!lcd_en) begin
            low_len++;
        end
        prev_en = lcd_en;
        prev_rw = lcd_rw;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issue one request from a negedge and wait for rsp_valid (bounded).
    // lat counts edges from the accept edge to the edge raising rsp_valid.
    task automatic run_op(input logic rs, input logic poll, input int gnt_delay,
                          input logic poke, output int lat, output int pulses,
                          output int breq_drops, output int early_act);
        int e_start;
        e_start    = e_cnt;
        e_base     = e_cnt;
        bus_gnt    = (gnt_delay == 0);
        req_rs     = rs;
        req_poll   = poll;
        req_valid  = 1'b1;
        lat        = -1;
        breq_drops = 0;
        early_act  = 0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (!bus_gnt && (lcd_en || lcd_rw || lcd_oeb)) early_act++;
            if (rsp_valid) begin
                lat = cyc;
                break;
            end
            if (!bus_req) breq_drops++;
            if (cyc == gnt_delay) bus_gnt = 1'b1;
            req_valid = poke && (cyc == 3 || cyc == 12);
        end
        req_valid = 1'b0;
        pulses = e_cnt - e_start;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_assert++;
            if (bus_req !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_bus_req cycle %0d: got %b, required 0", i, bus_req);
            end
        end
        n_assert++;
        if ({req_ready, rsp_valid, rsp_timeout, lcd_en, lcd_rw, lcd_rs, lcd_oeb} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/valid/tmo/en/rw/rs/oeb=%b, required 1000000",
                     {req_ready, rsp_valid, rsp_timeout, lcd_en, lcd_rw, lcd_rs, lcd_oeb});
        end
        n_assert++;
        if (rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h, required 00", rsp_data);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        n_assert++;
        if (bus_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: bus_req=%b req_ready=%b, required 0/1", bus_req, req_ready);
        end
    endtask

    task automatic test_data_read();
        int lat, pulses, drops, early;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h41;
        run_op(1'b1, 1'b0, 0, 1'b0, lat, pulses, drops, early);
        n_assert++;
        if (lat !== 15) begin
            n_fail++;
            $display("FAIL data_latency: got %0d, required 15", lat);
        end
        n_assert++;
        if (rsp_data !== 8'h41 || rsp_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL data_rsp: data=%h tmo=%b, required 41/0", rsp_data, rsp_timeout);
        end
        n_assert++;
        if (pulses !== 1 || last_high_len !== 5 || last_rs !== 1'b1) begin
            n_fail++;
            $display("FAIL data_e_pulse: pulses=%0d high=%0d rs=%b, required 1/5/1",
                     pulses, last_high_len, last_rs);
        end
        n_assert++;
        if (bus_req !== 1'b0 || lcd_oeb !== 1'b0 || lcd_rw !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL data_release: bus_req=%b oeb=%b rw=%b ready=%b, required 0/0/0/1",
                     bus_req, lcd_oeb, lcd_rw, req_ready);
        end
        @(negedge clk);
        n_assert++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h41) begin
            n_fail++;
            $display("FAIL data_rsp_hold: valid=%b data=%h, required 0/41", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_poll_clear();
        int lat, pulses, drops, early;
        model_mem[0] = 8'h81;
        model_mem[1] = 8'h82;
        model_mem[2] = 8'h83;
        for (int i = 3; i < 8; i++) model_mem[i] = 8'h05;
        run_op(1'b1, 1'b1, 0, 1'b0, lat, pulses, drops, early);
        n_assert++;
        if (pulses !== 4 || drops !== 0) begin
            n_fail++;
            $display("FAIL poll_pulses: pulses=%0d bus_req_drops=%0d, required 4/0", pulses, drops);
        end
        n_assert++;
        if (lat !== 51) begin
            n_fail++;
            $display("FAIL poll_latency: got %0d, required 51", lat);
        end
        n_assert++;
        if (rsp_data !== 8'h05 || rsp_timeout !== 1'b0 || last_rs !== 1'b0) begin
            n_fail++;
            $display("FAIL poll_rsp: data=%h tmo=%b rs=%b, required 05/0/0",
                     rsp_data, rsp_timeout, last_rs);
        end
        @(negedge clk);
    endtask

    task automatic test_poll_timeout();
        int lat, pulses, drops, early;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h80;
        run_op(1'b0, 1'b1, 0, 1'b0, lat, pulses, drops, early);
        n_assert++;
        if (pulses !== 4 || lat !== 51) begin
            n_fail++;
            $display("FAIL timeout_pulses: pulses=%0d lat=%0d, required 4/51", pulses, lat);
        end
        n_assert++;
        if (rsp_data !== 8'h80 || rsp_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_rsp: data=%h tmo=%b, required 80/1", rsp_data, rsp_timeout);
        end
        @(negedge clk);
    endtask

    task automatic test_gnt_delay();
        int lat, pulses, drops, early;
        // BF set on a non-poll read must still report no timeout.
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h9A;
        run_op(1'b0, 1'b0, 7, 1'b1, lat, pulses, drops, early);
        n_assert++;
        if (lat !== 22 || early !== 0) begin
            n_fail++;
            $display("FAIL gnt_delay: lat=%0d early_activity=%0d, required 22/0", lat, early);
        end
        n_assert++;
        if (rsp_data !== 8'h9A || rsp_timeout !== 1'b0 || pulses !== 1 || last_rs !== 1'b0) begin
            n_fail++;
            $display("FAIL gnt_delay_rsp: data=%h tmo=%b pulses=%0d rs=%b, required 9A/0/1/0",
                     rsp_data, rsp_timeout, pulses, last_rs);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_assert++;
            if (bus_req !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ignored_req: bus_req=%b ready=%b valid=%b, required 0/1/0",
                         bus_req, req_ready, rsp_valid);
            end
        end
    endtask

    task automatic test_reset_mid_ehigh();
        logic found;
        int   extra;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h55;
        e_base    = e_cnt;
        bus_gnt   = 1'b1;
        req_rs    = 1'b1;
        req_poll  = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_en) begin
                found = 1'b1;
                break;
            end
        end
        n_assert++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_e_seen: got %b, required 1", found);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_assert++;
        if ({lcd_en, lcd_rw, lcd_oeb, bus_req, rsp_valid, req_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL mid_rst_outputs: en/rw/oeb/req/valid/ready=%b, required 000001",
                     {lcd_en, lcd_rw, lcd_oeb, bus_req, rsp_valid, req_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid || bus_req || lcd_en) extra++;
        end
        n_assert++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL mid_rst_quiet: %0d active cycles after reset, required 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_poll_clear();
        test_poll_timeout();
        test_gnt_delay();
        test_reset_mid_ehigh();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
